multu_hilo_unit: RTL and testbench

- Iterative unsigned shift-add multiplier with architectural HI/LO registers.
- Sits directly downstream of the ALU-control decoder, beside the main ALU in the execute stage.
- Performs MULTU over multiple cycles and serves MFHI/MFLO reads, using the decoder's 4-bit ALU control code.
- Raises a stall toward the pipeline/FSM controller while a product is pending.

---
 rtl/multu_hilo_unit_if.sv | 26 ++
 rtl/multu_hilo_unit.sv | 118 +++++++++++
 tb/tb_multu_hilo_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/multu_hilo_unit_if.sv
// Request/response bundle between the execute-stage control and the MULTU/HI/LO unit.
// The unit takes the slave side; control or a testbench takes the master side.
interface multu_hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic             mul_start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_ctrl;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output mul_start, a, b, alu_ctrl,
    input  busy, done, stall, hi, lo, rd_data
  );

  modport slave (
    input  mul_start, a, b, alu_ctrl,
    output busy, done, stall, hi, lo, rd_data
  );
endinterface

// File: rtl/multu_hilo_unit.sv
// Iterative unsigned shift-add multiplier with architectural HI/LO registers.
// One multiplier bit is consumed per cycle; HI/LO only change on the completing edge.
// Optional macro MULTU_EARLY_TERM_EN: finish as soon as the remaining multiplier bits
// are all zero (latency = max(1, msb(b)+1)); otherwise latency is always WIDTH cycles.
module multu_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6    // 2**CNT_W must exceed WIDTH
) (
  input logic               clk,
  input logic               rst,   // async, active low
  multu_hilo_unit_if.slave  bus
);
  localparam logic [3:0] ALU_MFHI = 4'b1010;
  localparam logic [3:0] ALU_MFLO = 4'b1011;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               r_state,  w_state_nxt;
  logic [2*WIDTH-1:0]   r_acc,    w_acc_nxt;
  logic [2*WIDTH-1:0]   r_mcand,  w_mcand_nxt;
  logic [WIDTH-1:0]     r_mplier, w_mplier_nxt;
  logic [CNT_W-1:0]     r_cnt,    w_cnt_nxt;
  logic [WIDTH-1:0]     r_hi,     w_hi_nxt;
  logic [WIDTH-1:0]     r_lo,     w_lo_nxt;
  logic                 r_done,   w_done_nxt;

  logic [2*WIDTH-1:0]   w_acc_sum;
  logic [WIDTH-1:0]     w_mplier_sh;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic                 w_last;
  logic                 w_busy;
  logic                 w_mfhi;
  logic                 w_mflo;

  // Datapath for one iteration: conditional add, then shift both operands.
  assign w_acc_sum   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_sh = r_mplier >> 1;
  assign w_cnt_inc   = r_cnt + CNT_W'(1);

`ifdef MULTU_EARLY_TERM_EN
  // No set bits left means every remaining iteration would add nothing.
  assign w_last = (w_cnt_inc == CNT_W'(WIDTH)) || (w_mplier_sh == '0);
`else
  assign w_last = (w_cnt_inc == CNT_W'(WIDTH));
`endif

  // Next-state and next-datapath values; every target holds by default.
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_cnt_nxt    = r_cnt;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_done_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.mul_start) begin
          w_mcand_nxt  = {{WIDTH{1'b0}}, bus.a};
          w_mplier_nxt = bus.b;
          w_acc_nxt    = '0;
          w_cnt_nxt    = '0;
          w_state_nxt  = RUN;
        end
      end
      RUN: begin
        w_acc_nxt    = w_acc_sum;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = w_mplier_sh;
        w_cnt_nxt    = w_cnt_inc;
        if (w_last) begin
          // Commit includes this iteration's add.
          w_hi_nxt    = w_acc_sum[2*WIDTH-1:WIDTH];
          w_lo_nxt    = w_acc_sum[WIDTH-1:0];
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any multiply and clears HI/LO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_cnt    <= w_cnt_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Busy is exactly the RUN state; stall holds back anything that needs HI/LO or the unit.
  assign w_busy = (r_state == RUN);
  assign w_mfhi = (bus.alu_ctrl == ALU_MFHI);
  assign w_mflo = (bus.alu_ctrl == ALU_MFLO);

  assign bus.busy    = w_busy;
  assign bus.done    = r_done;
  assign bus.stall   = w_busy & (bus.mul_start | w_mfhi | w_mflo);
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.rd_data = w_mfhi ? r_hi : (w_mflo ? r_lo : '0);
endmodule

// File: tb/tb_multu_hilo_unit.sv
// Directed bench for multu_hilo_unit: reset, full-range product, small products,
// MFHI/MFLO stall during RUN, ignored restart, mid-run reset, back-to-back starts.
module tb_multu_hilo_unit;
  localparam int W = 32;
`ifdef MULTU_EARLY_TERM_EN
  localparam int EARLY = 1;
`else
  localparam int EARLY = 0;
`endif
  localparam logic [3:0] MFHI = 4'b1010;
  localparam logic [3:0] MFLO = 4'b1011;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  multu_hilo_unit_if #(.WIDTH(W)) bus ();

  multu_hilo_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] mb);
    if (EARLY == 0) return W;
    for (int i = W - 1; i >= 0; i--) if (mb[i]) return i + 1;
    return 1;
  endfunction

  // Pulse mul_start for one edge; returns at the negedge after that edge.
  task automatic start(input logic [W-1:0] ta, input logic [W-1:0] tb_);
    bus.a = ta;
    bus.b = tb_;
    bus.mul_start = 1'b1;
    @(negedge clk);
    bus.mul_start = 1'b0;
  endtask

  // Advance negedges until done (bounded); n counts cycles since the start edge.
  task automatic wait_done(inout int n, output int nb);
    nb = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      if (bus.busy === 1'b1) nb++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_mul(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo, input string tag);
    int n;
    int nb;
    int el;
    el = exp_lat(tb_);
    start(ta, tb_);
    chk({tag, "_busy_rise"}, 64'(bus.busy), 64'd1);
    n = 0;
    wait_done(n, nb);
    chk({tag, "_latency"}, 64'(n), 64'(el));
    chk({tag, "_busy_cycles"}, 64'(nb), 64'(el));
    chk({tag, "_hi"}, 64'(bus.hi), 64'(ehi));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(elo));
    chk({tag, "_busy_fall"}, 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int n;
    int nb;
    int dcnt;
    int rst_at;
    rst = 1'b0;
    bus.mul_start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.alu_ctrl = 4'b0000;
    repeat (2) @(negedge clk);

    // Reset state
    bus.alu_ctrl = MFHI;
    bus.mul_start = 1'b1;
    #1;
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_rd", 64'(bus.rd_data), 64'd0);
    bus.mul_start = 1'b0;
    bus.alu_ctrl = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Small product
    run_mul(32'd3, 32'd5, 32'd0, 32'd15, "m3x5");

    // Full-range product, also preloads HI/LO for the next test
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "mff");
    bus.alu_ctrl = MFHI;
    #1 chk("rd_mfhi", 64'(bus.rd_data), 64'hFFFF_FFFE);
    bus.alu_ctrl = MFLO;
    #1 chk("rd_mflo", 64'(bus.rd_data), 64'h1);
    bus.alu_ctrl = 4'b0010;
    #1 chk("rd_other", 64'(bus.rd_data), 64'h0);
    chk("stall_idle", 64'(bus.stall), 64'd0);
    @(negedge clk);

    // Reads and restart during RUN
    start(32'd7, 32'd9);
    n = 0;
    bus.alu_ctrl = MFHI;
    #1;
    chk("run_stall_mfhi", 64'(bus.stall), 64'd1);
    chk("run_rd_oldhi", 64'(bus.rd_data), 64'hFFFF_FFFE);
    @(negedge clk);
    n++;
    bus.alu_ctrl = 4'b0000;
    bus.a = 32'd100;
    bus.mul_start = 1'b1;
    #1 chk("run_stall_start", 64'(bus.stall), 64'd1);
    @(negedge clk);
    n++;
    bus.mul_start = 1'b0;
    bus.alu_ctrl = MFLO;
    #1;
    chk("run_rd_oldlo", 64'(bus.rd_data), 64'h1);
    chk("run_hi_hold", 64'(bus.hi), 64'hFFFF_FFFE);
    bus.alu_ctrl = 4'b0000;
    wait_done(n, nb);
    chk("m7x9_latency", 64'(n), 64'(exp_lat(32'd9)));
    chk("m7x9_hi", 64'(bus.hi), 64'd0);
    chk("m7x9_lo", 64'(bus.lo), 64'd63);
    repeat (3) @(negedge clk);
    chk("restart_ignored_busy", 64'(bus.busy), 64'd0);
    chk("restart_ignored_lo", 64'(bus.lo), 64'd63);

    // Reset mid-run
    rst_at = (EARLY != 0) ? 2 : 10;
    start(32'd10, 32'd10);
    repeat (rst_at) @(negedge clk);
    chk("midrst_pre_busy", 64'(bus.busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_hi", 64'(bus.hi), 64'd0);
    chk("midrst_lo", 64'(bus.lo), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) dcnt++;
      @(negedge clk);
    end
    chk("midrst_no_done", 64'(dcnt), 64'd0);
    run_mul(32'd10, 32'd10, 32'd0, 32'd100, "m10x10");

    // Zero multiplier
    run_mul(32'd12345, 32'd0, 32'd0, 32'd0, "mb0");

    // Start in the done cycle; done must still drop
    start(32'd4, 32'd5);
    n = 0;
    wait_done(n, nb);
    chk("m4x5_lo", 64'(bus.lo), 64'd20);
    start(32'd2, 32'd3);
    chk("b2b_done_drop", 64'(bus.done), 64'd0);
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    n = 0;
    wait_done(n, nb);
    chk("b2b_latency", 64'(n), 64'(exp_lat(32'd3)));
    chk("b2b_lo", 64'(bus.lo), 64'd6);
    chk("b2b_hi", 64'(bus.hi), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
